// File: rtl/lvds_tx_framer_if.sv
// Byte-stream input and dibit output bundle for lvds_tx_framer.
// The master drives payload bytes; the slave (the framer) drives the
// serializer dibit and the frame status flags.
`timescale 1ns/1ps
interface lvds_tx_framer_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [1:0] lvds_tx_data;
  logic       busy;
  logic       underrun;

  modport master (
    output in_data, in_valid, in_last,
    input  in_ready, lvds_tx_data, busy, underrun
  );

  modport slave (
    input  in_data, in_valid, in_last,
    output in_ready, lvds_tx_data, busy, underrun
  );
endinterface

// File: rtl/lvds_tx_framer.sv
// LVDS transmit framer: preamble (0x55 x PREAMBLE_BYTES), SFD 0xD5, payload,
// optional CRC-16-CCITT trailer, then an idle gap of GAP_CYCLES dibits.
// Every byte leaves as four dibits, least significant pair first.
// Optional feature: define TX_CRC16_EN to append the payload CRC (low byte
// first) after the last payload byte.
`timescale 1ns/1ps
module lvds_tx_framer #(
  parameter int PREAMBLE_BYTES = 4,
  parameter int GAP_CYCLES     = 8
) (
  input  logic            tx_slowclk,
  input  logic            reset_n,
  lvds_tx_framer_if.slave bus
);

`ifdef TX_CRC16_EN
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_PAY, S_CRC, S_GAP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_PAY, S_GAP} state_t;
`endif

  localparam logic [3:0] PRE_LAST = 4'(PREAMBLE_BYTES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  state_t     state_q;
  logic [1:0] dcnt_q;   // index of the dibit currently on the line
  logic [3:0] bcnt_q;   // preamble byte index / CRC byte index
  logic [7:0] gcnt_q;   // idle gap cycle index
  logic [7:0] sh_q;     // remaining dibits of the byte on the line
  logic       last_q;   // byte on the line closes the frame
  logic [1:0] dout_q;
  logic       ready_q;
  logic       busy_q;
  logic       urun_q;
  logic       take;
  logic       starve;

  // A ready cycle either loads the next byte or aborts the frame.
  assign take   = ready_q &  bus.in_valid;
  assign starve = ready_q & ~bus.in_valid;

`ifdef TX_CRC16_EN
  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // CRC-16-CCITT, poly 0x1021, data bits fed LSB first into the MSB feedback.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else              c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_d = crc16_byte(crc_q, bus.in_data);
`endif

  // Frame sequencer; every output is registered alongside the state.
  always_ff @(posedge tx_slowclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
      sh_q    <= '0;
      last_q  <= 1'b0;
      dout_q  <= 2'b00;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      urun_q  <= 1'b0;
`ifdef TX_CRC16_EN
      crc_q   <= '0;
`endif
    end else begin
      urun_q  <= 1'b0;
      ready_q <= 1'b0;
      if (take) begin
        // First dibit goes out straight from the input so the stream has no bubble.
        state_q <= S_PAY;
        dcnt_q  <= 2'd0;
        dout_q  <= bus.in_data[1:0];
        sh_q    <= {2'b00, bus.in_data[7:2]};
        last_q  <= bus.in_last;
`ifdef TX_CRC16_EN
        crc_q   <= crc_d;
`endif
      end else if (starve) begin
        // Source ran dry mid-frame: abandon it and fall into the gap.
        state_q <= S_GAP;
        urun_q  <= 1'b1;
        dout_q  <= 2'b00;
        gcnt_q  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            dout_q <= 2'b00;
            if (bus.in_valid) begin
              state_q <= S_PRE;
              dout_q  <= 2'b01;
              dcnt_q  <= 2'd0;
              bcnt_q  <= '0;
              busy_q  <= 1'b1;
`ifdef TX_CRC16_EN
              crc_q   <= 16'hFFFF;
`endif
            end
          end
          S_PRE: begin
            dout_q <= 2'b01;
            if (dcnt_q == 2'd3) begin
              dcnt_q <= 2'd0;
              if (bcnt_q == PRE_LAST) begin
                state_q <= S_SFD;
                bcnt_q  <= '0;
              end else begin
                bcnt_q <= bcnt_q + 4'd1;
              end
            end else begin
              dcnt_q <= dcnt_q + 2'd1;
            end
          end
          S_SFD: begin
            // 0xD5 = 01,01,01,11; the 4th dibit is the first ready cycle.
            dcnt_q  <= dcnt_q + 2'd1;
            dout_q  <= (dcnt_q == 2'd2) ? 2'b11 : 2'b01;
            ready_q <= (dcnt_q == 2'd2);
          end
          S_PAY: begin
            if (dcnt_q != 2'd3) begin
              dcnt_q  <= dcnt_q + 2'd1;
              dout_q  <= sh_q[1:0];
              sh_q    <= {2'b00, sh_q[7:2]};
              ready_q <= (dcnt_q == 2'd2) && !last_q;
            end else begin
              // Only the final byte reaches here; others end in take/starve.
              dcnt_q <= 2'd0;
`ifdef TX_CRC16_EN
              state_q <= S_CRC;
              bcnt_q  <= '0;
              dout_q  <= crc_q[1:0];
              sh_q    <= {2'b00, crc_q[7:2]};
`else
              state_q <= S_GAP;
              gcnt_q  <= '0;
              dout_q  <= 2'b00;
`endif
            end
          end
`ifdef TX_CRC16_EN
          S_CRC: begin
            if (dcnt_q != 2'd3) begin
              dcnt_q <= dcnt_q + 2'd1;
              dout_q <= sh_q[1:0];
              sh_q   <= {2'b00, sh_q[7:2]};
            end else if (bcnt_q == 4'd0) begin
              dcnt_q <= 2'd0;
              bcnt_q <= 4'd1;
              dout_q <= crc_q[9:8];
              sh_q   <= {2'b00, crc_q[15:10]};
            end else begin
              state_q <= S_GAP;
              dcnt_q  <= 2'd0;
              bcnt_q  <= '0;
              gcnt_q  <= '0;
              dout_q  <= 2'b00;
            end
          end
`endif
          S_GAP: begin
            dout_q <= 2'b00;
            if (gcnt_q == GAP_LAST) begin
              state_q <= S_IDLE;
              gcnt_q  <= '0;
              busy_q  <= 1'b0;
            end else begin
              gcnt_q <= gcnt_q + 8'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            dout_q  <= 2'b00;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.lvds_tx_data = dout_q;
  assign bus.in_ready     = ready_q;
  assign bus.busy         = busy_q;
  assign bus.underrun     = urun_q;

endmodule

// File: tb/tb_lvds_tx_framer.sv
// Scoreboard bench for lvds_tx_framer: each frame's expected per-cycle line
// state (dibit, busy, in_ready, underrun) is queued when the frame is offered
// and compared cycle by cycle on the falling edge.
`timescale 1ns/1ps
module tb_lvds_tx_framer;
  localparam int PB = 4;
  localparam int GC = 8;

  typedef struct packed {
    logic [1:0] d;
    logic       busy;
    logic       rdy;
    logic       urun;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];
  exp_t ce;
  logic [7:0] fb [16];

  always #5 clk = ~clk;

  lvds_tx_framer_if bus();

  lvds_tx_framer #(.PREAMBLE_BYTES(PB), .GAP_CYCLES(GC)) dut (
    .tx_slowclk(clk),
    .reset_n   (rst_n),
    .bus       (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference CRC: poly 0x1021, data LSB first, MSB-side feedback.
  function automatic logic [15:0] model_crc(input logic [15:0] c, input logic [7:0] b);
    logic [16:0] t;
    for (int i = 0; i < 8; i++) begin
      t = {c, 1'b0};
      if (t[16] != b[i]) c = t[15:0] ^ 16'h1021;
      else               c = t[15:0];
    end
    return c;
  endfunction

  task automatic push_exp(input logic [1:0] d, input logic b, input logic r, input logic u);
    exp_t e;
    e.d = d; e.busy = b; e.rdy = r; e.urun = u;
    exp_q.push_back(e);
  endtask

  task automatic push_byte(input logic [7:0] v, input logic rdy_last);
    for (int i = 0; i < 4; i++) push_exp(v[2*i +: 2], 1'b1, (i == 3) && rdy_last, 1'b0);
  endtask

  // Expected line activity for one frame of fb[0..n-1]; stall = index of the
  // in_ready pulse the source misses (0 = at SFD), -1 for none.
  task automatic push_frame(input int n, input int stall);
    logic [15:0] crc;
    crc = 16'hFFFF;
    for (int i = 0; i < 4*PB; i++) push_exp(2'b01, 1'b1, 1'b0, 1'b0);
    push_exp(2'b01, 1'b1, 1'b0, 1'b0);
    push_exp(2'b01, 1'b1, 1'b0, 1'b0);
    push_exp(2'b01, 1'b1, 1'b0, 1'b0);
    push_exp(2'b11, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      if (k == stall) begin
        push_exp(2'b00, 1'b1, 1'b0, 1'b1);
        for (int g = 1; g < GC; g++) push_exp(2'b00, 1'b1, 1'b0, 1'b0);
        push_exp(2'b00, 1'b0, 1'b0, 1'b0);
        return;
      end
      push_byte(fb[k], k < n-1);
      crc = model_crc(crc, fb[k]);
    end
`ifdef TX_CRC16_EN
    push_byte(crc[7:0], 1'b0);
    push_byte(crc[15:8], 1'b0);
`endif
    for (int g = 0; g < GC; g++) push_exp(2'b00, 1'b1, 1'b0, 1'b0);
    push_exp(2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  // Line monitor.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      check_val("dibit",    32'(bus.lvds_tx_data), 32'(ce.d));
      check_val("busy",     32'(bus.busy),         32'(ce.busy));
      check_val("in_ready", 32'(bus.in_ready),     32'(ce.rdy));
      check_val("underrun", 32'(bus.underrun),     32'(ce.urun));
    end
  end

  // Offer one frame; garbage data/last is present whenever in_ready is low.
  task automatic send_frame(input int n, input int stall, input bit keep, input bit chained);
    int guard;
    if (!chained) begin
      @(negedge clk); #1;
    end
    push_frame(n, stall);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'($urandom);
    bus.in_last  = 1'b1;
    for (int k = 0; k < n; k++) begin
      guard = 0;
      do begin
        @(negedge clk);
        guard++;
      end while (bus.in_ready !== 1'b1 && guard < 200);
      check_val("ready_wait", 32'(bus.in_ready), 32'd1);
      if (bus.in_ready !== 1'b1) begin
        bus.in_valid = 1'b0;
        return;
      end
      #1;
      if (k == stall) begin
        bus.in_valid = 1'b0;
        return;
      end
      bus.in_data = fb[k];
      bus.in_last = (k == n-1);
      @(posedge clk); #1;
      bus.in_data = 8'($urandom);
      bus.in_last = 1'($urandom);
      if (k == n-1 && !keep) bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    #1;
    check_val("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;

    // Reset values while reset_n is held low.
    #12;
    check_val("rst_dibit",    32'(bus.lvds_tx_data), 32'd0);
    check_val("rst_busy",     32'(bus.busy),         32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready),     32'd0);
    check_val("rst_underrun", 32'(bus.underrun),     32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    push_exp(2'b00, 1'b0, 1'b0, 1'b0);
    push_exp(2'b00, 1'b0, 1'b0, 1'b0);
    drain();

    // Single byte 0xA5.
    fb[0] = 8'hA5;
    send_frame(1, -1, 1'b0, 1'b0);
    drain();

    // Three bytes, valid held high throughout.
    fb[0] = 8'h00; fb[1] = 8'hFF; fb[2] = 8'h3C;
    send_frame(3, -1, 1'b0, 1'b0);
    drain();

    // Source stalls at the 2nd in_ready pulse.
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33;
    send_frame(3, 1, 1'b0, 1'b0);
    push_exp(2'b00, 1'b0, 1'b0, 1'b0);
    push_exp(2'b00, 1'b0, 1'b0, 1'b0);
    drain();

    // Source stalls at the SFD in_ready pulse.
    fb[0] = 8'hC3; fb[1] = 8'h3C;
    send_frame(2, 0, 1'b0, 1'b0);
    drain();

    // Back-to-back frames with in_valid never dropped.
    fb[0] = 8'h81;
    send_frame(1, -1, 1'b1, 1'b0);
    fb[0] = 8'h7E; fb[1] = 8'h42;
    send_frame(2, -1, 1'b0, 1'b1);
    drain();

    // ASCII "123456789".
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    send_frame(9, -1, 1'b0, 1'b0);
    drain();

    // Reset pulsed in the middle of the payload.
    @(negedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h96;
    bus.in_last  = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (bus.in_ready !== 1'b1 && guard < 200);
    check_val("ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check_val("pay_first_dibit", 32'(bus.lvds_tx_data), 32'd2);
    check_val("pay_busy",        32'(bus.busy),         32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_dibit",    32'(bus.lvds_tx_data), 32'd0);
    check_val("mid_rst_busy",     32'(bus.busy),         32'd0);
    check_val("mid_rst_in_ready", 32'(bus.in_ready),     32'd0);
    check_val("mid_rst_underrun", 32'(bus.underrun),     32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    push_exp(2'b00, 1'b0, 1'b0, 1'b0);
    push_exp(2'b00, 1'b0, 1'b0, 1'b0);
    drain();
    fb[0] = 8'h5A;
    send_frame(1, -1, 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
